uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx_pkg.sv | 33 +++
 rtl/uart_rx_baud.sv | 27 ++
 rtl/uart_rx.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: FSM encoding, data-length codes
// and the smallest bit period the bit timer can handle.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } rxState_e;

  localparam logic [1:0]  BITS_5      = 2'b00;
  localparam logic [1:0]  BITS_6      = 2'b01;
  localparam logic [1:0]  BITS_7      = 2'b10;
  localparam logic [1:0]  BITS_8      = 2'b11;
  localparam logic [15:0] MIN_DIVISOR = 16'd4;

  // Index of the final data bit for a given length code.
  function automatic logic [2:0] lastBitIndex(input logic [1:0] code);
    logic [2:0] idx;
    case (code)
      BITS_5:  idx = 3'd4;
      BITS_6:  idx = 3'd5;
      BITS_7:  idx = 3'd6;
      BITS_8:  idx = 3'd7;
      default: idx = 3'd7;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/uart_rx_baud.sv
// Bit-timing down-counter: load with a cycle count, tick_o is high while the
// count sits at zero so the FSM samples on that cycle and reloads.
module uart_rx_baud
  import uart_rx_pkg::*;
(
  input  logic        m_clock,
  input  logic        p_reset,
  input  logic        load_i,
  input  logic [15:0] loadValue_i,
  output logic        tick_o
);

  logic [15:0] count_q;

  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= loadValue_i;
    end else if (count_q != '0) begin
      count_q <= count_q - 16'd1;
    end
  end

  assign tick_o = (count_q == '0);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronises the line, frames start/data/parity/stop and
// holds one received byte with error flags until the consumer acknowledges.
module uart_rx
  import uart_rx_pkg::*;
(
  input  logic        m_clock,
  input  logic        p_reset,
  input  logic        RxD_i,
  input  logic [15:0] Freq_Divide_Param_i,
  input  logic [1:0]  Rx_BitLength_i,
  input  logic        Rx_ParityEN_i,
  input  logic        Rx_OddParity_i,
  input  logic        Rx_Enable_i,
  input  logic        Rx_Ack_i,
  output logic [7:0]  Rx_Data_o,
  output logic        Rx_Valid_o,
  output logic        Rx_ParityErr_o,
  output logic        Rx_FrameErr_o,
  output logic        Rx_Overrun_o,
  output logic        Rx_Busy_o
);

  rxState_e    state_q, state_d;
  logic        rxMeta_q, rxs_q, rxPrev_q;
  logic [15:0] nDiv_q;
  logic [1:0]  bitLen_q;
  logic        parEn_q, odd_q;
  logic [2:0]  bitCnt_q, bitCnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        pErr_q, pErr_d;
  logic [7:0]  data_q;
  logic        valid_q, parityErr_q, frameErr_q, overrun_q;

  logic        cfgLatch, baudLoad, baudTick, frameDone, frameErrNow;
  logic [15:0] baudValue, nIn;

  // Divisors below the minimum would leave no room for a mid-bit sample.
  assign nIn = (Freq_Divide_Param_i < MIN_DIVISOR) ? MIN_DIVISOR : Freq_Divide_Param_i;

  uart_rx_baud u_baud (
    .m_clock     (m_clock),
    .p_reset     (p_reset),
    .load_i      (baudLoad),
    .loadValue_i (baudValue),
    .tick_o      (baudTick)
  );

  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) begin
      rxMeta_q <= 1'b1;
      rxs_q    <= 1'b1;
      rxPrev_q <= 1'b1;
      state_q  <= ST_IDLE;
      bitCnt_q <= '0;
      shift_q  <= '0;
      pErr_q   <= 1'b0;
      nDiv_q   <= MIN_DIVISOR;
      bitLen_q <= BITS_8;
      parEn_q  <= 1'b0;
      odd_q    <= 1'b0;
    end else begin
      rxMeta_q <= RxD_i;
      rxs_q    <= rxMeta_q;
      rxPrev_q <= rxs_q;
      state_q  <= state_d;
      bitCnt_q <= bitCnt_d;
      shift_q  <= shift_d;
      pErr_q   <= pErr_d;
      if (cfgLatch) begin
        nDiv_q   <= nIn;
        bitLen_q <= Rx_BitLength_i;
        parEn_q  <= Rx_ParityEN_i;
        odd_q    <= Rx_OddParity_i;
      end
    end
  end

  // Frame sequencing; every sample point reloads the bit timer with N-1.
  always_comb begin
    state_d     = state_q;
    bitCnt_d    = bitCnt_q;
    shift_d     = shift_q;
    pErr_d      = pErr_q;
    cfgLatch    = 1'b0;
    baudLoad    = 1'b0;
    baudValue   = nDiv_q - 16'd1;
    frameDone   = 1'b0;
    frameErrNow = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Rx_Enable_i && !rxs_q && rxPrev_q) begin
          cfgLatch  = 1'b1;
          baudLoad  = 1'b1;
          baudValue = (nIn >> 1) - 16'd1;
          bitCnt_d  = '0;
          shift_d   = '0;
          pErr_d    = 1'b0;
          state_d   = ST_START;
        end
      end
      ST_START: begin
        if (baudTick) begin
          if (!rxs_q) begin
            baudLoad = 1'b1;
            state_d  = ST_DATA;
          end else begin
            state_d  = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (baudTick) begin
          shift_d[bitCnt_q] = rxs_q;
          baudLoad          = 1'b1;
          if (bitCnt_q == lastBitIndex(bitLen_q)) begin
            state_d = parEn_q ? ST_PARITY : ST_STOP;
          end else begin
            bitCnt_d = bitCnt_q + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        if (baudTick) begin
          pErr_d   = ((^shift_q) ^ rxs_q) != odd_q;
          baudLoad = 1'b1;
          state_d  = ST_STOP;
        end
      end
      ST_STOP: begin
        if (baudTick) begin
          frameDone   = 1'b1;
          frameErrNow = !rxs_q;
          state_d     = rxs_q ? ST_IDLE : ST_BREAK;
        end
      end
      ST_BREAK: begin
        if (rxs_q) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_q != ST_IDLE && !Rx_Enable_i) begin
      state_d   = ST_IDLE;
      frameDone = 1'b0;
      baudLoad  = 1'b0;
    end
  end

  // Holding register: an ack in the completing cycle frees the slot first.
  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) begin
      data_q      <= '0;
      valid_q     <= 1'b0;
      parityErr_q <= 1'b0;
      frameErr_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else if (frameDone && (!valid_q || Rx_Ack_i)) begin
      data_q      <= shift_q;
      parityErr_q <= pErr_q;
      frameErr_q  <= frameErrNow;
      valid_q     <= 1'b1;
      overrun_q   <= 1'b0;
    end else if (frameDone) begin
      overrun_q   <= 1'b1;
    end else if (Rx_Ack_i && valid_q) begin
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end
  end

  assign Rx_Data_o      = data_q;
  assign Rx_Valid_o     = valid_q;
  assign Rx_ParityErr_o = parityErr_q;
  assign Rx_FrameErr_o  = frameErr_q;
  assign Rx_Overrun_o   = overrun_q;
  assign Rx_Busy_o      = (state_q != ST_IDLE);

endmodule
